// File: rtl/astar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : astar_pkg
// Description : Shared types, costs and helpers for the A* neighbour stages.
// Revision    : 1.0
// ============================================================================
package astar_pkg;

    localparam int COORD_W = 8;
    localparam int COST_W  = 16;

    localparam logic [COST_W-1:0] STRAIGHT_COST = 16'd256;
    localparam logic [COST_W-1:0] DIAG_COST     = 16'd362;

    // y grows downward, so "S" is +1 in y
    typedef enum logic [2:0] {
        DIR_E  = 3'd0,
        DIR_SE = 3'd1,
        DIR_S  = 3'd2,
        DIR_SW = 3'd3,
        DIR_W  = 3'd4,
        DIR_NW = 3'd5,
        DIR_N  = 3'd6,
        DIR_NE = 3'd7
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DIR_CHECK = 3'd1,
        ST_MAP_WAIT  = 3'd2,
        ST_EMIT      = 3'd3,
        ST_FINISH    = 3'd4
    } state_t;

    function automatic logic signed [1:0] dir_dx(input logic [2:0] d);
        case (d)
            3'd0, 3'd1, 3'd7: dir_dx = 2'sd1;
            3'd3, 3'd4, 3'd5: dir_dx = -2'sd1;
            default:          dir_dx = 2'sd0;
        endcase
    endfunction

    function automatic logic signed [1:0] dir_dy(input logic [2:0] d);
        case (d)
            3'd1, 3'd2, 3'd3: dir_dy = 2'sd1;
            3'd5, 3'd6, 3'd7: dir_dy = -2'sd1;
            default:          dir_dy = 2'sd0;
        endcase
    endfunction

    // odd direction indices are the diagonals
    function automatic logic [COST_W-1:0] step_cost(input logic [2:0] d);
        step_cost = d[0] ? DIAG_COST : STRAIGHT_COST;
    endfunction

    function automatic logic [COST_W-1:0] sat_add(input logic [COST_W-1:0] a,
                                                  input logic [COST_W-1:0] b);
        logic [COST_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        sat_add = s[COST_W] ? {COST_W{1'b1}} : s[COST_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/astar_heuristic.sv
`default_nettype none
// ============================================================================
// Module      : astar_heuristic
// Description : Combinational octile distance from (nx, ny) to the goal, Q8.8.
// Revision    : 1.0
// ============================================================================
module astar_heuristic
    import astar_pkg::*;
#(
    parameter int GOAL_X = 39,
    parameter int GOAL_Y = 39
) (
    input  logic [COORD_W-1:0] i_nx,
    input  logic [COORD_W-1:0] i_ny,
    output logic [COST_W-1:0]  o_h
);

    localparam logic [COORD_W-1:0] C_GOAL_X = COORD_W'(GOAL_X);
    localparam logic [COORD_W-1:0] C_GOAL_Y = COORD_W'(GOAL_Y);

    logic [COORD_W-1:0] w_dx;
    logic [COORD_W-1:0] w_dy;
    logic [COORD_W-1:0] w_dmin;
    logic [COORD_W-1:0] w_dmax;
    logic [31:0]        w_h_full;

    assign w_dx   = (i_nx >= C_GOAL_X) ? (i_nx - C_GOAL_X) : (C_GOAL_X - i_nx);
    assign w_dy   = (i_ny >= C_GOAL_Y) ? (i_ny - C_GOAL_Y) : (C_GOAL_Y - i_ny);
    assign w_dmin = (w_dx < w_dy) ? w_dx : w_dy;
    assign w_dmax = (w_dx < w_dy) ? w_dy : w_dx;

    assign w_h_full = 32'(w_dmin) * 32'(DIAG_COST)
                    + 32'(w_dmax - w_dmin) * 32'(STRAIGHT_COST);

    assign o_h = (|w_h_full[31:COST_W]) ? {COST_W{1'b1}} : w_h_full[COST_W-1:0];

endmodule
`default_nettype wire

// File: rtl/astar_neighbor_gen.sv
`default_nettype none
// ============================================================================
// Module      : astar_neighbor_gen
// Description : Walks the 8 neighbours of a node, filters by bounds/map, emits g/f.
// Revision    : 1.0
// ============================================================================
module astar_neighbor_gen
    import astar_pkg::*;
#(
    parameter int GRID_W = 40,
    parameter int GRID_H = 40,
    parameter int GOAL_X = 39,
    parameter int GOAL_Y = 39
) (
    input  logic               sync,
    input  logic               reset,
    input  logic               cur_valid,
    output logic               cur_ready,
    input  logic [COORD_W-1:0] cur_x,
    input  logic [COORD_W-1:0] cur_y,
    input  logic [COST_W-1:0]  cur_g,
    output logic               map_rd_en,
    output logic [COORD_W-1:0] map_rd_x,
    output logic [COORD_W-1:0] map_rd_y,
    input  logic               map_rd_data,
    output logic               nb_valid,
    input  logic               nb_ready,
    output logic [COORD_W-1:0] nb_x,
    output logic [COORD_W-1:0] nb_y,
    output logic [2:0]         nb_dir,
    output logic [COST_W-1:0]  nb_g,
    output logic [COST_W-1:0]  nb_f,
    output logic               scan_done,
    output logic [3:0]         nb_count,
    output logic               err
);

    localparam int SW = COORD_W + 2;
    localparam logic signed [SW-1:0]   C_ZERO     = '0;
    localparam logic signed [SW-1:0]   C_GRID_W_S = SW'(GRID_W);
    localparam logic signed [SW-1:0]   C_GRID_H_S = SW'(GRID_H);
    localparam logic [COORD_W-1:0]     C_GRID_W_U = COORD_W'(GRID_W);
    localparam logic [COORD_W-1:0]     C_GRID_H_U = COORD_W'(GRID_H);

    state_t             r_state;
    state_t             w_next;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [COST_W-1:0]  r_g;
    logic [2:0]         r_dir;
    logic [3:0]         r_count;
    logic               r_err;
    logic [COORD_W-1:0] r_nb_x;
    logic [COORD_W-1:0] r_nb_y;
    logic [2:0]         r_nb_dir;
    logic [COST_W-1:0]  r_nb_g;
    logic [COST_W-1:0]  r_nb_f;

    logic signed [1:0]    w_ddx;
    logic signed [1:0]    w_ddy;
    logic signed [SW-1:0] w_cx;
    logic signed [SW-1:0] w_cy;
    logic                 w_inb;
    logic                 w_last;
    logic                 w_bad_node;
    logic                 w_rd_en;
    logic [COORD_W-1:0]   w_nx;
    logic [COORD_W-1:0]   w_ny;
    logic [COST_W-1:0]    w_h;
    logic [COST_W-1:0]    w_g;
    logic [COST_W-1:0]    w_f;

    // Candidate computed with two guard bits so x-1 at x=0 reads as -1
    assign w_ddx = dir_dx(r_dir);
    assign w_ddy = dir_dy(r_dir);
    assign w_cx  = $signed({2'b00, r_x}) + {{COORD_W{w_ddx[1]}}, w_ddx};
    assign w_cy  = $signed({2'b00, r_y}) + {{COORD_W{w_ddy[1]}}, w_ddy};
    assign w_inb = (w_cx >= C_ZERO) && (w_cx < C_GRID_W_S)
                && (w_cy >= C_ZERO) && (w_cy < C_GRID_H_S);
    assign w_nx  = w_cx[COORD_W-1:0];
    assign w_ny  = w_cy[COORD_W-1:0];

    assign w_last     = (r_dir == DIR_NE);
    assign w_bad_node = (cur_x >= C_GRID_W_U) || (cur_y >= C_GRID_H_U);

    astar_heuristic #(
        .GOAL_X (GOAL_X),
        .GOAL_Y (GOAL_Y)
    ) u_heuristic (
        .i_nx (w_nx),
        .i_ny (w_ny),
        .o_h  (w_h)
    );

    assign w_g = sat_add(r_g, step_cost(r_dir));
    assign w_f = sat_add(w_g, w_h);

    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cur_valid) w_next = w_bad_node ? ST_FINISH : ST_DIR_CHECK;
            end
            ST_DIR_CHECK: begin
                if (w_inb) begin
                    w_rd_en = 1'b1;
                    w_next  = ST_MAP_WAIT;
                end else if (w_last) begin
                    w_next = ST_FINISH;
                end
            end
            ST_MAP_WAIT: begin
                if (map_rd_data) w_next = w_last ? ST_FINISH : ST_DIR_CHECK;
                else             w_next = ST_EMIT;
            end
            ST_EMIT: begin
                if (nb_ready) w_next = w_last ? ST_FINISH : ST_DIR_CHECK;
            end
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sync) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_g      <= '0;
            r_dir    <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
            r_nb_x   <= '0;
            r_nb_y   <= '0;
            r_nb_dir <= '0;
            r_nb_g   <= '0;
            r_nb_f   <= '0;
        end else begin
            r_state <= w_next;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cur_valid) begin
                        r_x     <= cur_x;
                        r_y     <= cur_y;
                        r_g     <= cur_g;
                        r_dir   <= '0;
                        r_count <= '0;
                        r_err   <= w_bad_node;
                    end
                end
                ST_DIR_CHECK: begin
                    if (!w_inb && !w_last) r_dir <= r_dir + 3'd1;
                end
                ST_MAP_WAIT: begin
                    if (map_rd_data) begin
                        if (!w_last) r_dir <= r_dir + 3'd1;
                    end else begin
                        r_nb_x   <= w_nx;
                        r_nb_y   <= w_ny;
                        r_nb_dir <= r_dir;
                        r_nb_g   <= w_g;
                        r_nb_f   <= w_f;
                    end
                end
                ST_EMIT: begin
                    if (nb_ready) begin
                        r_count <= r_count + 4'd1;
                        if (!w_last) r_dir <= r_dir + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cur_ready = (r_state == ST_IDLE) && !reset;
    assign map_rd_en = w_rd_en;
    assign map_rd_x  = w_rd_en ? w_nx : '0;
    assign map_rd_y  = w_rd_en ? w_ny : '0;
    assign nb_valid  = (r_state == ST_EMIT);
    assign nb_x      = r_nb_x;
    assign nb_y      = r_nb_y;
    assign nb_dir    = r_nb_dir;
    assign nb_g      = r_nb_g;
    assign nb_f      = r_nb_f;
    assign scan_done = (r_state == ST_FINISH);
    assign nb_count  = (r_state == ST_FINISH) ? r_count : 4'd0;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_astar_neighbor_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_astar_neighbor_gen
// Description : Directed bench for astar_neighbor_gen with a 40x40 obstacle map.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_astar_neighbor_gen;

    logic        sync = 1'b0;
    logic        reset = 1'b1;
    logic        cur_valid = 1'b0;
    logic        cur_ready;
    logic [7:0]  cur_x = '0;
    logic [7:0]  cur_y = '0;
    logic [15:0] cur_g = '0;
    logic        map_rd_en;
    logic [7:0]  map_rd_x;
    logic [7:0]  map_rd_y;
    logic        map_rd_data = 1'b0;
    logic        nb_valid;
    logic        nb_ready = 1'b1;
    logic [7:0]  nb_x;
    logic [7:0]  nb_y;
    logic [2:0]  nb_dir;
    logic [15:0] nb_g;
    logic [15:0] nb_f;
    logic        scan_done;
    logic [3:0]  nb_count;
    logic        err;

    astar_neighbor_gen dut (
        .sync        (sync),
        .reset       (reset),
        .cur_valid   (cur_valid),
        .cur_ready   (cur_ready),
        .cur_x       (cur_x),
        .cur_y       (cur_y),
        .cur_g       (cur_g),
        .map_rd_en   (map_rd_en),
        .map_rd_x    (map_rd_x),
        .map_rd_y    (map_rd_y),
        .map_rd_data (map_rd_data),
        .nb_valid    (nb_valid),
        .nb_ready    (nb_ready),
        .nb_x        (nb_x),
        .nb_y        (nb_y),
        .nb_dir      (nb_dir),
        .nb_g        (nb_g),
        .nb_f        (nb_f),
        .scan_done   (scan_done),
        .nb_count    (nb_count),
        .err         (err)
    );

    always #5 sync = ~sync;

    // Registered map read port: data appears the cycle after the strobe
    logic obs [0:39][0:39];
    always @(posedge sync) begin
        if (map_rd_en && map_rd_x < 8'd40 && map_rd_y < 8'd40)
            map_rd_data <= obs[int'(map_rd_y)][int'(map_rd_x)];
        else
            map_rd_data <= 1'b0;
    end

    int errors = 0;
    int checks = 0;

    int          n_nb, n_reads, first_idx, done_idx, err_idx, done_cnt;
    logic [7:0]  rx [8];
    logic [7:0]  ry [8];
    logic [2:0]  rd [8];
    logic [15:0] rg [8];
    logic [15:0] rf [8];

    task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs_v, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge sync);
        #1;
    endtask

    task automatic clear_rec();
        n_nb = 0; n_reads = 0; first_idx = -1; done_idx = -1; err_idx = -1; done_cnt = -1;
    endtask

    task automatic start_node(input logic [7:0] x, input logic [7:0] y, input logic [15:0] g);
        chk("cur_ready_before_accept", cur_ready, 1);
        cur_x = x; cur_y = y; cur_g = g; cur_valid = 1'b1;
        tick();
        cur_valid = 1'b0;
    endtask

    // Observes cycles starting at index idx0 (1 = first cycle after accept)
    task automatic collect(input int idx0);
        int idx;
        idx = idx0;
        while (idx <= 80) begin
            if (map_rd_en) n_reads++;
            if (err) err_idx = idx;
            if (nb_valid && first_idx < 0) first_idx = idx;
            if (nb_valid && nb_ready) begin
                if (n_nb < 8) begin
                    rx[n_nb] = nb_x; ry[n_nb] = nb_y; rd[n_nb] = nb_dir;
                    rg[n_nb] = nb_g; rf[n_nb] = nb_f;
                end
                n_nb++;
            end
            if (scan_done) begin
                done_idx = idx;
                done_cnt = int'(nb_count);
                break;
            end
            tick();
            idx++;
        end
        chk("scan_done_within_bound", (done_idx >= 0), 1);
        tick();
    endtask

    initial begin
        logic [2:0]  exp_d [6];
        logic [7:0]  hx, hy;
        logic [15:0] hg, hf;
        int          bad;

        for (int yy = 0; yy < 40; yy++)
            for (int xx = 0; xx < 40; xx++)
                obs[yy][xx] = 1'b0;

        // Reset state
        tick(); tick();
        chk("reset_cur_ready", cur_ready, 0);
        chk("reset_nb_valid", nb_valid, 0);
        chk("reset_scan_done", scan_done, 0);
        chk("reset_err", err, 0);
        chk("reset_map_rd_en", map_rd_en, 0);
        reset = 1'b0;
        tick();
        chk("post_reset_cur_ready", cur_ready, 1);

        // Corner (0,0): only E, SE, S survive
        clear_rec();
        start_node(8'd0, 8'd0, 16'd0);
        collect(1);
        chk("c00_count", n_nb, 3);
        chk("c00_nb_count", done_cnt, 3);
        chk("c00_d0_xy", {rx[0], ry[0], 5'd0, rd[0]}, {8'd1, 8'd0, 8'd0});
        chk("c00_d0_g", rg[0], 256);
        chk("c00_d0_f", rf[0], 14268);
        chk("c00_d1_xy", {rx[1], ry[1], 5'd0, rd[1]}, {8'd1, 8'd1, 8'd1});
        chk("c00_d1_g", rg[1], 362);
        chk("c00_d1_f", rf[1], 14118);
        chk("c00_d2_xy", {rx[2], ry[2], 5'd0, rd[2]}, {8'd0, 8'd1, 8'd2});
        chk("c00_d2_f", rf[2], 14268);

        // Interior (10,10) on an empty map
        clear_rec();
        start_node(8'd10, 8'd10, 16'd0);
        collect(1);
        chk("c1010_count", n_nb, 8);
        chk("c1010_nb_count", done_cnt, 8);
        chk("c1010_first_valid", first_idx, 3);
        chk("c1010_done_idx", done_idx, 25);
        chk("c1010_reads", n_reads, 8);
        for (int i = 0; i < 8; i++) chk("c1010_dir_order", rd[i], i);
        chk("c1010_d0_f", rf[0], 10648);
        chk("c1010_d7_xy", {rx[7], ry[7]}, {8'd11, 8'd9});
        chk("c1010_d7_g", rg[7], 362);
        chk("c1010_d7_f", rf[7], 11010);

        // Obstacles east and north of (10,10)
        obs[10][11] = 1'b1;
        obs[9][10]  = 1'b1;
        clear_rec();
        start_node(8'd10, 8'd10, 16'd0);
        collect(1);
        chk("obs_count", n_nb, 6);
        chk("obs_nb_count", done_cnt, 6);
        chk("obs_reads", n_reads, 8);
        exp_d = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
        for (int i = 0; i < 6; i++) chk("obs_dir_order", rd[i], exp_d[i]);
        obs[10][11] = 1'b0;
        obs[9][10]  = 1'b0;

        // Backpressure on the first neighbour
        clear_rec();
        nb_ready = 1'b0;
        start_node(8'd10, 8'd10, 16'd0);
        chk("bp_rd_en_dir0", map_rd_en, 1);
        tick(); tick();
        chk("bp_nb_valid", nb_valid, 1);
        hx = nb_x; hy = nb_y; hg = nb_g; hf = nb_f;
        chk("bp_first_xy", {hx, hy}, {8'd11, 8'd10});
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (!nb_valid || nb_x !== hx || nb_y !== hy || nb_g !== hg || nb_f !== hf || nb_dir !== 3'd0) bad++;
            if (map_rd_en) bad++;
        end
        chk("bp_stable_no_reads", bad, 0);
        nb_ready = 1'b1;
        collect(8);
        chk("bp_count", n_nb, 8);
        chk("bp_nb_count", done_cnt, 8);

        // Goal-adjacent: SE lands on the goal, h=0
        clear_rec();
        start_node(8'd38, 8'd38, 16'd100);
        collect(1);
        chk("goal_count", n_nb, 8);
        chk("goal_d0_f", rf[0], 612);
        chk("goal_d1_xy", {rx[1], ry[1]}, {8'd39, 8'd39});
        chk("goal_d1_g", rg[1], 462);
        chk("goal_d1_f", rf[1], 462);

        // Saturation
        clear_rec();
        start_node(8'd10, 8'd10, 16'hFFF0);
        collect(1);
        chk("sat_d0_g", rg[0], 16'hFFFF);
        chk("sat_d0_f", rf[0], 16'hFFFF);

        // Out-of-grid current node
        clear_rec();
        start_node(8'd40, 8'd5, 16'd0);
        collect(1);
        chk("bad_err_idx", err_idx, 1);
        chk("bad_done_idx", done_idx, 1);
        chk("bad_nb_count", done_cnt, 0);
        chk("bad_reads", n_reads, 0);
        chk("bad_err_cleared", err, 0);

        // Reset during EMIT
        nb_ready = 1'b0;
        start_node(8'd10, 8'd10, 16'd0);
        tick(); tick();
        chk("rst_emit_nb_valid", nb_valid, 1);
        reset = 1'b1;
        tick();
        chk("rst_nb_valid_dropped", nb_valid, 0);
        chk("rst_cur_ready_low", cur_ready, 0);
        reset = 1'b0;
        nb_ready = 1'b1;
        tick();
        chk("rst_cur_ready_high", cur_ready, 1);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (scan_done || nb_valid || map_rd_en) bad++;
            tick();
        end
        chk("rst_no_scan_done", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
